// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Drives an 8-bit ALU board that is loaded through a 4-bit nibble bus. A
// request (two bytes, a command and a carry) is accepted in IDLE. It is then
// streamed to the board as four nibbles: A lo, A hi, B lo, B hi. The sequencer
// waits SETTLE cycles for the board to settle, captures the result, and
// presents it on a valid/ready response port.
//
// Parameters
//   SELECT_W        width of the ALU command field
//   SETTLE          cycles (1..15) waited after the last nibble load
//   OP_COUNT_RESET  value op_count takes in reset (normally zero)
//
// Ports
//   clock, reset                    single clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_cmd, req_carry request payload
//   alu_arg, alu_select_args,       nibble load bus to the ALU board; the
//   alu_lo_hi_arg, alu_load_args    nibble index k = {alu_lo_hi_arg, alu_select_args}
//   alu_command, alu_carry_in       ALU function and carry, held per operation
//   alu_result, alu_flags,          ALU board outputs
//   alu_carry_out
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_flags, rsp_carry response payload
//   abort                           synchronous cancel, returns to IDLE
//   busy                            high whenever an operation is in flight
//   op_count                        saturating count of completed responses
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int          SELECT_W       = 3,
    parameter int          SETTLE         = 1,
    parameter logic [15:0] OP_COUNT_RESET = 16'h0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_a,
    input  logic [7:0]          req_b,
    input  logic [SELECT_W-1:0] req_cmd,
    input  logic                req_carry,
    output logic [3:0]          alu_arg,
    output logic                alu_select_args,
    output logic                alu_lo_hi_arg,
    output logic                alu_load_args,
    output logic [SELECT_W-1:0] alu_command,
    output logic                alu_carry_in,
    input  logic [7:0]          alu_result,
    input  logic [7:0]          alu_flags,
    input  logic                alu_carry_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [7:0]          rsp_result,
    output logic [7:0]          rsp_flags,
    output logic                rsp_carry,
    input  logic                abort,
    output logic                busy,
    output logic [15:0]         op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RESP
    } state_t;

    // Counter value on the final settle cycle.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    function automatic logic [3:0] pick_nibble(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [1:0] k);
        case (k)
            2'd0:    return a[3:0];
            2'd1:    return a[7:4];
            2'd2:    return b[3:0];
            default: return b[7:4];
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Control state
    state_t              state_q, state_d;
    logic [3:0]          step_q, step_d;
    logic [15:0]         count_q, count_d;

    // Stage 0: operands latched at transfer, nibble bus and command registers
    logic [7:0]          a_p0, a_d;
    logic [7:0]          b_p0, b_d;
    logic [SELECT_W-1:0] cmd_p0, cmd_d;
    logic                cin_p0, cin_d;
    logic [3:0]          arg_p0, arg_d;
    logic                sel_p0, sel_d;
    logic                lohi_p0, lohi_d;
    logic                load_p0, load_d;

    // Stage 1: captured ALU response
    logic [7:0]          res_p1, res_d;
    logic [7:0]          flags_p1, flags_d;
    logic                carry_p1, carry_d;
    logic                vld_p1, vld_d;

    logic [1:0]          next_k;

    assign req_ready = (state_q == S_IDLE) & ~abort;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        count_d = count_q;
        a_d     = a_p0;
        b_d     = b_p0;
        cmd_d   = cmd_p0;
        cin_d   = cin_p0;
        arg_d   = arg_p0;
        sel_d   = sel_p0;
        lohi_d  = lohi_p0;
        load_d  = load_p0;
        res_d   = res_p1;
        flags_d = flags_p1;
        carry_d = carry_p1;
        vld_d   = vld_p1;
        next_k  = step_q[1:0] + 2'd1;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    // Nibble 0 goes out immediately so it lands on the next edge.
                    a_d     = req_a;
                    b_d     = req_b;
                    cmd_d   = req_cmd;
                    cin_d   = req_carry;
                    step_d  = 4'd0;
                    arg_d   = pick_nibble(req_a, req_b, 2'd0);
                    sel_d   = 1'b0;
                    lohi_d  = 1'b0;
                    load_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (step_q[1:0] == 2'd3) begin
                    // Bus values stay put through SETTLE; only the strobe drops.
                    load_d  = 1'b0;
                    step_d  = 4'd0;
                    state_d = S_SETTLE;
                end else begin
                    step_d = step_q + 4'd1;
                    arg_d  = pick_nibble(a_p0, b_p0, next_k);
                    sel_d  = next_k[0];
                    lohi_d = next_k[1];
                end
            end
            S_SETTLE: begin
                if (step_q == SETTLE_LAST) begin
                    res_d   = alu_result;
                    flags_d = alu_flags;
                    carry_d = alu_carry_out;
                    vld_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    count_d = sat_inc(count_q);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                load_d  = 1'b0;
                vld_d   = 1'b0;
            end
        endcase

        // Abort wins over everything, including a response handshake.
        if (abort) begin
            state_d = S_IDLE;
            step_d  = 4'd0;
            load_d  = 1'b0;
            vld_d   = 1'b0;
            count_d = count_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            step_q   <= 4'd0;
            count_q  <= OP_COUNT_RESET;
            a_p0     <= 8'd0;
            b_p0     <= 8'd0;
            cmd_p0   <= '0;
            cin_p0   <= 1'b0;
            arg_p0   <= 4'd0;
            sel_p0   <= 1'b0;
            lohi_p0  <= 1'b0;
            load_p0  <= 1'b0;
            res_p1   <= 8'd0;
            flags_p1 <= 8'd0;
            carry_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            count_q  <= count_d;
            a_p0     <= a_d;
            b_p0     <= b_d;
            cmd_p0   <= cmd_d;
            cin_p0   <= cin_d;
            arg_p0   <= arg_d;
            sel_p0   <= sel_d;
            lohi_p0  <= lohi_d;
            load_p0  <= load_d;
            res_p1   <= res_d;
            flags_p1 <= flags_d;
            carry_p1 <= carry_d;
            vld_p1   <= vld_d;
        end
    end

    assign alu_arg         = arg_p0;
    assign alu_select_args = sel_p0;
    assign alu_lo_hi_arg   = lohi_p0;
    assign alu_load_args   = load_p0;
    assign alu_command     = cmd_p0;
    assign alu_carry_in    = cin_p0;
    assign rsp_valid       = vld_p1;
    assign rsp_result      = res_p1;
    assign rsp_flags       = flags_p1;
    assign rsp_carry       = carry_p1;
    assign busy            = (state_q != S_IDLE);
    assign op_count        = count_q;

endmodule
